// File: rtl/gate_pattern_sequencer_pkg.sv
// ============================================================================
//  gate_seq_pkg
//  Shared types, sizes and the pattern helper for the gate pattern sequencer.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package gate_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } seq_state_t;

    localparam int NUM_PATTERNS = 8;
    localparam int STEP_W       = 3;
    localparam int RESP_W       = 16;

    // Returns {a,b,d} for a step; a is the MSB.
    function automatic logic [2:0] pattern_of(input logic [STEP_W-1:0] stp, input logic gray);
        pattern_of = gray ? (stp ^ (stp >> 1)) : stp;
    endfunction

endpackage

`default_nettype wire

// File: rtl/gate_pattern_sequencer_if.sv
// ============================================================================
//  gate_pattern_sequencer_if
//  Control, stimulus and response signals between sequencer and gate side.
//  Revision: 1.0
// ============================================================================
`default_nettype none

interface gate_pattern_sequencer_if;
    import gate_seq_pkg::*;

    logic              start;
    logic              abort;
    logic              out1;
    logic              out2;
    logic              a;
    logic              b;
    logic              d;
    logic              busy;
    logic              done;
    logic [RESP_W-1:0] resp;
    logic [STEP_W-1:0] step;

    modport master (
        input  start, abort, out1, out2,
        output a, b, d, busy, done, resp, step
    );

    modport slave (
        output start, abort, out1, out2,
        input  a, b, d, busy, done, resp, step
    );
endinterface

`default_nettype wire

// File: rtl/gate_pattern_sequencer_hold_counter.sv
// ============================================================================
//  gate_hold_counter
//  Loadable down-counter timing how long each pattern is held.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module gate_hold_counter #(
    parameter int WIDTH = 3
) (
    input  wire             clk,
    input  wire             rst,
    input  wire             load,
    input  wire             enable,
    input  wire [WIDTH-1:0] load_value,
    output logic            is_zero
);

    logic [WIDTH-1:0] r_count;

    // Saturates at zero so a stalled final step cannot wrap around.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_value;
        end else if (enable && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign is_zero = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/gate_pattern_sequencer.sv
// ============================================================================
//  gate_pattern_sequencer
//  Sweeps all eight a/b/d patterns, holds each, and captures out1/out2.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module gate_pattern_sequencer
    import gate_seq_pkg::*;
#(
    parameter int HOLD_CYCLES = 5,
    parameter bit GRAY_ORDER  = 1'b0
) (
    input  wire                      clk,
    input  wire                      rst,
    gate_pattern_sequencer_if.master bus
);

    localparam int              CNT_W        = (HOLD_CYCLES < 2) ? 1 : $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0] C_RELOAD    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [STEP_W-1:0] C_LAST_STEP = STEP_W'(NUM_PATTERNS - 1);

    seq_state_t        r_state;
    logic [STEP_W-1:0] r_step;
    logic [RESP_W-1:0] r_resp;
    logic [2:0]        r_abd;
    logic              r_busy;
    logic              r_done;

    logic w_cnt_zero;
    logic w_accept;
    logic w_capture;
    logic w_last_step;
    logic w_cnt_load;
    logic w_cnt_en;

    assign w_accept    = (r_state == IDLE) && bus.start;
    assign w_capture   = (r_state == DRIVE) && !bus.abort && w_cnt_zero;
    assign w_last_step = (r_step == C_LAST_STEP);
    assign w_cnt_load  = w_accept || (w_capture && !w_last_step);
    assign w_cnt_en    = (r_state == DRIVE);

    gate_hold_counter #(
        .WIDTH (CNT_W)
    ) u_hold_counter (
        .clk        (clk),
        .rst        (rst),
        .load       (w_cnt_load),
        .enable     (w_cnt_en),
        .load_value (C_RELOAD),
        .is_zero    (w_cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_step  <= '0;
            r_resp  <= '0;
            r_abd   <= 3'b000;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_state <= DRIVE;
                        r_step  <= '0;
                        r_resp  <= '0;
                        r_busy  <= 1'b1;
                        r_abd   <= pattern_of('0, GRAY_ORDER);
                    end
                end
                DRIVE: begin
                    // Abort outranks the capture that would happen on the same edge.
                    if (bus.abort) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_abd   <= 3'b000;
                    end else if (w_cnt_zero) begin
                        r_resp[{r_step, 1'b0} +: 2] <= {bus.out2, bus.out1};
                        if (w_last_step) begin
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_abd   <= 3'b000;
                        end else begin
                            r_step <= r_step + 1'b1;
                            r_abd  <= pattern_of(STEP_W'(r_step + 1'b1), GRAY_ORDER);
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_abd   <= 3'b000;
                end
            endcase
        end
    end

    assign bus.a    = r_abd[2];
    assign bus.b    = r_abd[1];
    assign bus.d    = r_abd[0];
    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.resp = r_resp;
    assign bus.step = r_step;

endmodule

`default_nettype wire
